// File: rtl/blk_bf5a2e.sv
// Debug-memory master for the Nios II debug slave.
// Turns the sysclk-stage command pulses (take_action_ocimem_a/b,
// take_no_action_ocimem_a) into single-word Avalon-MM reads and writes.
// It then hands MonDReg, monitor_ready and monitor_error back to the
// debug-slave wrapper, which scans them out over JTAG.
// Optional feature: define CPU_DEBUG_MEM_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES cycles of waitrequest. The abort returns 32'hDEAD_BEEF
// and raises monitor_error.
module blk_bf5a2e #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;

    logic cmd_any;
    logic timeout_hit;
    logic unused_jdo;

    assign cmd_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // jdo[37:36] and jdo[2:0] carry nothing this block decodes.
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef CPU_DEBUG_MEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q, to_cnt_d;

    // The counter rests at zero in IDLE, so it starts clean on every new transaction.
    assign timeout_hit = (state_q != ST_IDLE) && avm_waitrequest && (to_cnt_q == TO_LAST);

    // Count stalled cycles of the transaction currently in flight.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (avm_waitrequest) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout;

    // Without the timeout the FSM waits on waitrequest for as long as it takes.
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // FSM state register; an async reset drops the strobes immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Commands are honoured only in IDLE, with priority a > b > no_action.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    state_d = jdo[35] ? ST_RD : ST_IDLE;
                end else if (take_action_ocimem_b) begin
                    state_d = ST_WR;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (timeout_hit || !avm_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes follow the registered state, one cycle after the command edge.
    always_comb begin
        avm_read  = (state_q == ST_RD);
        avm_write = (state_q == ST_WR);
    end

    // Datapath updates: command capture, completion, overrun and abort.
    always_comb begin
        addr_d     = addr_q;
        mon_dreg_d = mon_dreg_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        error_d    = error_q;
        busy_d     = busy_q;
        if (state_q == ST_IDLE) begin
            if (take_action_ocimem_a) begin
                addr_d = jdo[16+ADDR_W:17];
                if (jdo[33]) begin
                    error_d = 1'b0;
                end
                if (jdo[35]) begin
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                wdata_d    = jdo[34:3];
                mon_dreg_d = jdo[34:3];
                busy_d     = 1'b1;
                ready_d    = 1'b0;
            end else if (take_no_action_ocimem_a) begin
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end
        end else begin
            // A command arriving mid-transaction is dropped and flagged as an overrun.
            if (cmd_any) begin
                error_d = 1'b1;
            end
            if (timeout_hit) begin
                mon_dreg_d = 32'hDEAD_BEEF;
                error_d    = 1'b1;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
            end else if (!avm_waitrequest) begin
                if (state_q == ST_RD) begin
                    mon_dreg_d = avm_readdata;
                end
                addr_d  = addr_q + 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            mon_dreg_q <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            mon_dreg_q <= mon_dreg_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign MonDReg        = mon_dreg_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
    assign busy           = busy_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_blk_bf5a2e.sv
// Scoreboard bench for blk_bf5a2e.
// The stimulus process keeps a reference model (current address, error flag,
// memory image) and queues the bus access each command should produce.
// A monitor pops the queue whenever the DUT completes or aborts an access.
module tb_blk_bf5a2e;

    localparam int AW = 9;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          ta_a, ta_b, tn_a;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error, busy;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_readdata;
    logic          avm_waitrequest;

    always #5 clk = ~clk;

    blk_bf5a2e #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    typedef struct {
        logic          wr;
        logic          to;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   mon;
        logic [AW-1:0] addr_after;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_len = 0;
    logic        mon_en = 1'b1;

    // Reference model state.
    logic [31:0]   ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] m_addr;
    logic [31:0]   m_mon;
    logic          m_err;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h1234_5678;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %s, expected none", name, what);
    endtask

    // Slave model: memory with a programmable stall length per access.
    logic [31:0] slave_mem [0:(1<<AW)-1];
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        for (int i = 0; i < (1 << AW); i++) slave_mem[i] = init_word(i);
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                if (wait_cnt < stall_len) begin
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    if (avm_write) slave_mem[avm_address] = avm_writedata;
                end
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt = 0;
            end
            avm_readdata = slave_mem[avm_address];
        end
    end

    // Monitor: pops the scoreboard on each completed or aborted access.
    initial begin
        exp_t          e;
        logic          prev_stall, prev_rd, prev_wr;
        logic [AW-1:0] prev_addr;
        logic [31:0]   prev_wd;
        int            run;
        prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
        prev_addr = '0; prev_wd = '0; run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en || !reset_n) begin
                prev_stall = 1'b0;
                run = 0;
            end else begin
                if (prev_stall && (avm_read || avm_write)) begin
                    chk("hold_read", avm_read, prev_rd);
                    chk("hold_write", avm_write, prev_wr);
                    chk("hold_addr", avm_address, prev_addr);
                    chk("hold_wdata", avm_writedata, prev_wd);
                end
                if ((avm_read || avm_write) && !avm_waitrequest) begin
                    if (sb_q.size() == 0) begin
                        fail("unexpected_access", "bus access");
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn %s addr=%03h data=%08h stall=%0d", avm_write ? "wr" : "rd",
                                 avm_address, avm_write ? avm_writedata : avm_readdata, run);
                        chk("acc_is_write", avm_write, e.wr);
                        chk("acc_not_timeout", 1'b0, e.to);
                        chk("acc_addr", avm_address, e.addr);
                        if (e.wr) begin
                            chk("acc_wdata", avm_writedata, e.wdata);
                            chk("acc_byteenable", avm_byteenable, 4'hF);
                        end
                        @(posedge clk);
                        #1;
                        chk("done_mondreg", MonDReg, e.mon);
                        chk("done_ready", monitor_ready, 1'b1);
                        chk("done_busy", busy, 1'b0);
                        chk("done_addr", avm_address, e.addr_after);
                    end
                    prev_stall = 1'b0;
                    run = 0;
                end else if (avm_read || avm_write) begin
                    prev_stall = 1'b1;
                    prev_rd = avm_read; prev_wr = avm_write;
                    prev_addr = avm_address; prev_wd = avm_writedata;
                    run++;
                end else begin
                    if (prev_stall) begin
`ifdef CPU_DEBUG_MEM_TIMEOUT_EN
                        if (sb_q.size() == 0) begin
                            fail("unexpected_abort", "abort");
                        end else begin
                            e = sb_q.pop_front();
                            $display("txn abort addr=%03h stall=%0d", avm_address, run);
                            chk("abort_expected", e.to, 1'b1);
                            chk("abort_stall_len", run, TO);
                            chk("abort_mondreg", MonDReg, e.mon);
                            chk("abort_ready", monitor_ready, 1'b1);
                            chk("abort_busy", busy, 1'b0);
                            chk("abort_addr", avm_address, e.addr_after);
                        end
`else
                        fail("strobe_dropped", "strobe release during stall");
`endif
                    end
                    prev_stall = 1'b0;
                    run = 0;
                end
            end
        end
    end

    task automatic send(input logic a, input logic b, input logic na, input logic [37:0] j);
        @(negedge clk);
        jdo = j; ta_a = a; ta_b = b; tn_a = na;
        @(negedge clk);
        ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
    endtask

    task automatic push_read();
        exp_t e;
        e.wr = 1'b0; e.to = 1'b0; e.addr = m_addr; e.wdata = '0;
        e.mon = ref_mem[m_addr]; e.addr_after = m_addr + 1'b1;
        m_mon = e.mon;
        m_addr = m_addr + 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic push_write(input logic [31:0] d);
        exp_t e;
        e.wr = 1'b1; e.to = 1'b0; e.addr = m_addr; e.wdata = d;
        e.mon = d; e.addr_after = m_addr + 1'b1;
        ref_mem[m_addr] = d;
        m_mon = d;
        m_addr = m_addr + 1'b1;
        sb_q.push_back(e);
    endtask

    // kind 0: ocimem_a (address, optional read/clear), 1: ocimem_b write, 2: read-next.
    task automatic do_cmd(input int kind, input logic [AW-1:0] a, input logic rd,
                          input logic clr, input logic [31:0] d);
        logic [37:0] j;
        j = {6'($urandom), $urandom};
        case (kind)
            0: begin
                j[16+AW:17] = a; j[35] = rd; j[33] = clr;
                m_addr = a;
                if (clr) m_err = 1'b0;
                if (rd) push_read();
                send(1'b1, 1'b0, 1'b0, j);
            end
            1: begin
                j[34:3] = d;
                push_write(d);
                send(1'b0, 1'b1, 1'b0, j);
            end
            default: begin
                push_read();
                send(1'b0, 1'b0, 1'b1, j);
            end
        endcase
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (busy) fail("wait_idle", "busy stuck high");
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_mondreg"}, MonDReg, m_mon);
        chk({tag, "_addr"}, avm_address, m_addr);
        chk({tag, "_error"}, monitor_error, m_err);
        chk({tag, "_ready"}, monitor_ready, 1'b1);
    endtask

    task automatic run_cmd(input string tag, input int kind, input logic [AW-1:0] a,
                           input logic rd, input logic clr, input logic [31:0] d);
        do_cmd(kind, a, rd, clr, d);
        wait_idle();
        idle_check(tag);
    endtask

    task automatic count_strobe(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (avm_read || avm_write) n++;
            else if (n > 0) break;
            @(negedge clk);
        end
    endtask

    // Stimulus and reference model.
    initial begin
        int          n;
        logic [37:0] j;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        reset_n = 1'b0; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", monitor_ready, 1'b1);
        chk("rst_error", monitor_error, 1'b0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_addr", avm_address, 9'h0);
        chk("rst_wdata", avm_writedata, 32'h0);
        chk("rst_byteenable", avm_byteenable, 4'hF);
        reset_n = 1'b1;

        // Address-and-read at 0x010: ready returns two cycles after the pulse.
        stall_len = 0;
        do_cmd(0, 9'h010, 1'b1, 1'b0, 32'h0);
        chk("lat_ready_c1", monitor_ready, 1'b0);
        chk("lat_busy_c1", busy, 1'b1);
        @(negedge clk);
        chk("lat_ready_c2", monitor_ready, 1'b1);
        chk("lat_mondreg", MonDReg, 32'h1234_5678);
        wait_idle();
        idle_check("addr_read");

        // Write at 1FF wraps the address to 0, then read-next at 000.
        run_cmd("set_1ff", 0, 9'h1FF, 1'b0, 1'b0, 32'h0);
        run_cmd("write_wrap", 1, 9'h0, 1'b0, 1'b0, 32'hCAFE_F00D);
        run_cmd("read_next", 2, 9'h0, 1'b0, 1'b0, 32'h0);

        // Coinciding pulses: ocimem_a wins, so only the address moves.
        j = {6'($urandom), $urandom};
        j[16+AW:17] = 9'h0A5; j[35] = 1'b0; j[33] = 1'b0;
        m_addr = 9'h0A5;
        send(1'b1, 1'b1, 1'b1, j);
        wait_idle();
        idle_check("priority");

        // Five stall cycles hold the read for six cycles.
        stall_len = 5;
        do_cmd(2, 9'h0, 1'b0, 1'b0, 32'h0);
        count_strobe(n);
        chk("stall_strobe_cycles", n, 6);
        wait_idle();
        idle_check("stall");

        // Overrun: a pulse while busy is dropped and sets the error flag.
        stall_len = 6;
        do_cmd(2, 9'h0, 1'b0, 1'b0, 32'h0);
        send(1'b0, 1'b0, 1'b1, {6'($urandom), $urandom});
        chk("overrun_error", monitor_error, 1'b1);
        m_err = 1'b1;
        wait_idle();
        idle_check("overrun");
        stall_len = 0;
        run_cmd("err_clear", 0, 9'($urandom), 1'b0, 1'b1, 32'h0);

        // Random command mix with short stalls.
        for (int i = 0; i < 60; i++) begin
            stall_len = $urandom_range(0, 3);
            run_cmd("rand", $urandom_range(0, 2), 9'($urandom), 1'($urandom),
                    1'($urandom), $urandom);
        end

        // Reset in the middle of a stalled read drops everything at once.
        run_cmd("pre_reset_wr", 1, 9'h0, 1'b0, 1'b0, 32'hA5A5_1234);
        mon_en = 1'b0;
        stall_len = 1000;
        send(1'b0, 1'b0, 1'b1, {6'($urandom), $urandom});
        repeat (2) @(negedge clk);
        chk("midrd_read_before", avm_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrd_read", avm_read, 1'b0);
        chk("midrd_ready", monitor_ready, 1'b1);
        chk("midrd_mondreg", MonDReg, 32'h0);
        chk("midrd_busy", busy, 1'b0);
        chk("midrd_addr", avm_address, 9'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stall_len = 0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        run_cmd("post_reset", 0, 9'h033, 1'b1, 1'b0, 32'h0);

        // Endless waitrequest.
        stall_len = 1000;
`ifdef CPU_DEBUG_MEM_TIMEOUT_EN
        begin
            exp_t e;
            e.wr = 1'b0; e.to = 1'b1; e.addr = m_addr; e.wdata = '0;
            e.mon = 32'hDEAD_BEEF; e.addr_after = m_addr;
            sb_q.push_back(e);
            m_mon = 32'hDEAD_BEEF;
            m_err = 1'b1;
        end
        send(1'b0, 1'b0, 1'b1, {6'($urandom), $urandom});
        count_strobe(n);
        chk("timeout_strobe_cycles", n, TO);
        wait_idle();
        idle_check("timeout");
        stall_len = 0;
`else
        mon_en = 1'b0;
        send(1'b0, 1'b0, 1'b1, {6'($urandom), $urandom});
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (avm_read) n++;
            @(negedge clk);
        end
        chk("no_timeout_hold", n, 100);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        stall_len = 0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something never returns.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
